// File: rtl/reaction_round_sequencer_pkg.sv
// Shared definitions for the reaction-round sequencer: state encoding,
// default parameters and saturating arithmetic helpers.
// Optional feature macro: REACT_SEQ_EARLY_PENALTY_EN (adds the GAP1P state).
package sequencer_pkg;

   localparam int DEF_ROUNDS  = 4;
   localparam int DEF_RT_W    = 16;
   localparam int DEF_SCORE_W = 8;

   // GAP1P is the post-foul gap that returns to DELAY within the same round.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELAY,
      ST_GAP1,
      ST_REACT,
      ST_GAP2,
      ST_OVER
`ifdef REACT_SEQ_EARLY_PENALTY_EN
      ,
      ST_GAP1P
`endif
   } state_t;

   // Widths up to 32 bits are handled; callers truncate the result back.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

   function automatic logic [31:0] sat_dec(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

endpackage

// File: rtl/reaction_round_sequencer_if.sv
// Bundle of the game-control, timer and display signals around the sequencer.
// master: the sequencer side; slave: the timer/player/display side.
interface reaction_round_sequencer_if
   import sequencer_pkg::*;
#(
   parameter int ROUNDS  = DEF_ROUNDS,
   parameter int RT_W    = DEF_RT_W,
   parameter int SCORE_W = DEF_SCORE_W
) ();
   localparam int RI_W = $clog2(ROUNDS + 1);

   logic              go;
   logic              btn;
   logic              clock_done;
   logic              start_clock;
   logic              led_on;
   logic              busy;
   logic              game_over;
   logic [RI_W-1:0]   round_idx;
   logic [SCORE_W-1:0] score;
   logic [RT_W-1:0]   last_rt;
   logic [RT_W-1:0]   best_rt;

   modport master (
      input  go, btn, clock_done,
      output start_clock, led_on, busy, game_over, round_idx, score, last_rt, best_rt
   );

   modport slave (
      output go, btn, clock_done,
      input  start_clock, led_on, busy, game_over, round_idx, score, last_rt, best_rt
   );
endinterface

// File: rtl/reaction_round_sequencer_rise_detect.sv
// Rising-edge detector for the (already synchronized) player button.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o
);
   logic prev_q;

   // Remember last cycle's level so a held button never looks like a new press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= sig_i;
   end

   assign rise_o = sig_i & ~prev_q;
endmodule

// File: rtl/reaction_round_sequencer.sv
// Reaction-game round controller driving an external delay timer.
// One timer expiry is the "get ready" delay, a second one the reaction timeout.
// Optional: REACT_SEQ_EARLY_PENALTY_EN makes a press during DELAY a foul.
// RT_W and SCORE_W must not exceed 32.
module reaction_round_sequencer
   import sequencer_pkg::*;
#(
   parameter int ROUNDS  = DEF_ROUNDS,
   parameter int RT_W    = DEF_RT_W,
   parameter int SCORE_W = DEF_SCORE_W
) (
   input  logic clk,
   input  logic rst_n,
   reaction_round_sequencer_if.master bus
);
   localparam int              RI_W       = $clog2(ROUNDS + 1);
   localparam logic [RI_W-1:0] LAST_ROUND = RI_W'(ROUNDS - 1);
   localparam logic [31:0]     RT_MAX     = 32'({RT_W{1'b1}});
   localparam logic [31:0]     SCORE_MAX  = 32'({SCORE_W{1'b1}});

   state_t             state_q, state_d;
   logic [RT_W-1:0]    rt_cnt_q, rt_cnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [RT_W-1:0]    last_rt_q, last_rt_d;
   logic [RT_W-1:0]    best_rt_q, best_rt_d;
   logic [RI_W-1:0]    round_idx_q, round_idx_d;
   logic               start_clock_q, start_clock_d;
   logic               led_on_q, led_on_d;
   logic               busy_q, busy_d;
   logic               game_over_q, game_over_d;
   logic               btn_rise;

   rise_detect u_rise (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (bus.btn),
      .rise_o (btn_rise)
   );

   // Next-state, result updates and registered-output decode from the next state.
   always_comb begin
      state_d     = state_q;
      rt_cnt_d    = rt_cnt_q;
      score_d     = score_q;
      last_rt_d   = last_rt_q;
      best_rt_d   = best_rt_q;
      round_idx_d = round_idx_q;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (bus.go) begin
               score_d     = '0;
               round_idx_d = '0;
               last_rt_d   = '0;
               best_rt_d   = '1;
               state_d     = ST_DELAY;
            end
         end
         ST_DELAY: begin
`ifdef REACT_SEQ_EARLY_PENALTY_EN
            if (btn_rise) begin
               score_d = SCORE_W'(sat_dec(32'(score_q)));
               state_d = ST_GAP1P;
            end else
`endif
            if (bus.clock_done) begin
               state_d = ST_GAP1;
            end
         end
         ST_GAP1: begin
            if (!bus.clock_done) begin
               rt_cnt_d = '0;
               state_d  = ST_REACT;
            end
         end
         ST_REACT: begin
            rt_cnt_d = RT_W'(sat_inc(32'(rt_cnt_q), RT_MAX));
            // A press wins over a simultaneous timeout.
            if (btn_rise) begin
               last_rt_d = rt_cnt_q;
               if (rt_cnt_q < best_rt_q) best_rt_d = rt_cnt_q;
               score_d = SCORE_W'(sat_inc(32'(score_q), SCORE_MAX));
               state_d = ST_GAP2;
            end else if (bus.clock_done) begin
               state_d = ST_GAP2;
            end
         end
         ST_GAP2: begin
            // Re-arm only once the timer has seen start_clock low and cleared.
            if (!bus.clock_done) begin
               if (round_idx_q == LAST_ROUND) begin
                  state_d = ST_OVER;
               end else begin
                  round_idx_d = round_idx_q + 1'b1;
                  state_d     = ST_DELAY;
               end
            end
         end
`ifdef REACT_SEQ_EARLY_PENALTY_EN
         ST_GAP1P: begin
            if (!bus.clock_done) state_d = ST_DELAY;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      start_clock_d = (state_d == ST_DELAY) || (state_d == ST_REACT);
      led_on_d      = (state_d == ST_REACT);
      game_over_d   = (state_d == ST_OVER);
      busy_d        = (state_d != ST_IDLE) && (state_d != ST_OVER);
   end

   // State and result registers; reset aborts any round in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         rt_cnt_q      <= '0;
         score_q       <= '0;
         last_rt_q     <= '0;
         best_rt_q     <= '1;
         round_idx_q   <= '0;
         start_clock_q <= 1'b0;
         led_on_q      <= 1'b0;
         busy_q        <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         rt_cnt_q      <= rt_cnt_d;
         score_q       <= score_d;
         last_rt_q     <= last_rt_d;
         best_rt_q     <= best_rt_d;
         round_idx_q   <= round_idx_d;
         start_clock_q <= start_clock_d;
         led_on_q      <= led_on_d;
         busy_q        <= busy_d;
         game_over_q   <= game_over_d;
      end
   end

   assign bus.start_clock = start_clock_q;
   assign bus.led_on      = led_on_q;
   assign bus.busy        = busy_q;
   assign bus.game_over   = game_over_q;
   assign bus.round_idx   = round_idx_q;
   assign bus.score       = score_q;
   assign bus.last_rt     = last_rt_q;
   assign bus.best_rt     = best_rt_q;
endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Directed bench for reaction_round_sequencer with a behavioural delay timer.
// Timer: clock_done rises delay_cycles cycles after start_clock rises and
// clears on the first edge that sees start_clock low.
// Honours REACT_SEQ_EARLY_PENALTY_EN for the foul scenario expectations.
module tb_reaction_round_sequencer;
   localparam int ROUNDS  = 4;
   localparam int RT_W    = 16;
   localparam int SCORE_W = 8;
`ifdef REACT_SEQ_EARLY_PENALTY_EN
   localparam int FOUL_SCORE = 0;
   localparam int FOUL_START = 0;
`else
   localparam int FOUL_SCORE = 1;
   localparam int FOUL_START = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   delay_cycles = 5;
   int   tcnt;

   always #5 clk = ~clk;

   reaction_round_sequencer_if #(.ROUNDS(ROUNDS), .RT_W(RT_W), .SCORE_W(SCORE_W)) bus ();

   reaction_round_sequencer #(.ROUNDS(ROUNDS), .RT_W(RT_W), .SCORE_W(SCORE_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Delay timer model.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt           <= 0;
         bus.clock_done <= 1'b0;
      end else if (!bus.start_clock) begin
         tcnt           <= 0;
         bus.clock_done <= 1'b0;
      end else if (tcnt >= delay_cycles - 1) begin
         bus.clock_done <= 1'b1;
      end else begin
         tcnt <= tcnt + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_start_clock"}, 32'(bus.start_clock), 32'd0);
      check_eq({pfx, "_led_on"},      32'(bus.led_on),      32'd0);
      check_eq({pfx, "_busy"},        32'(bus.busy),        32'd0);
      check_eq({pfx, "_game_over"},   32'(bus.game_over),   32'd0);
      check_eq({pfx, "_round_idx"},   32'(bus.round_idx),   32'd0);
      check_eq({pfx, "_score"},       32'(bus.score),       32'd0);
      check_eq({pfx, "_last_rt"},     32'(bus.last_rt),     32'd0);
      check_eq({pfx, "_best_rt"},     32'(bus.best_rt),     32'hFFFF);
   endtask

   task automatic wait_led(input logic v, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.led_on == v) ok = 1'b1;
      end
      if (!ok) check_eq({tag, "_led_wait_timeout"}, 32'(bus.led_on), 32'(v));
   endtask

   task automatic wait_over(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.game_over) ok = 1'b1;
      end
      if (!ok) check_eq({tag, "_over_wait_timeout"}, 32'(bus.game_over), 32'd1);
   endtask

   task automatic wait_delay(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.start_clock && !bus.led_on) ok = 1'b1;
      end
      if (!ok) check_eq({tag, "_delay_wait_timeout"}, 32'(bus.start_clock), 32'd1);
   endtask

   task automatic start_game();
      @(negedge clk);
      bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
   endtask

   // Press so the hit is sampled on the REACT edge where rt_cnt == n.
   task automatic play_round(input int n, input string tag);
      wait_led(1'b1, tag);
      repeat (n) @(negedge clk);
      bus.btn = 1'b1;
      @(negedge clk);
      bus.btn = 1'b0;
      check_eq({tag, "_led_off_after_hit"}, 32'(bus.led_on), 32'd0);
   endtask

   initial begin
      bus.go  = 1'b0;
      bus.btn = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("init");
      rst_n = 1'b1;
      @(negedge clk);

      // Game A: hit on REACT cycle 3 every round.
      start_game();
      check_eq("A_busy_after_go",  32'(bus.busy),        32'd1);
      check_eq("A_start_after_go", 32'(bus.start_clock), 32'd1);
      play_round(3, "A_r0");
      check_eq("A_r0_last_rt", 32'(bus.last_rt), 32'd3);
      check_eq("A_r0_score",   32'(bus.score),   32'd1);
      for (int r = 1; r < 4; r++) play_round(3, "A_rn");
      wait_over("A");
      check_eq("A_score",     32'(bus.score),     32'd4);
      check_eq("A_last_rt",   32'(bus.last_rt),   32'd3);
      check_eq("A_best_rt",   32'(bus.best_rt),   32'd3);
      check_eq("A_game_over", 32'(bus.game_over), 32'd1);
      check_eq("A_round_idx", 32'(bus.round_idx), 32'd3);
      check_eq("A_busy",      32'(bus.busy),      32'd0);

      // Game B: no presses, four timeouts; also checks clearing on restart.
      start_game();
      check_eq("B_game_over_cleared", 32'(bus.game_over), 32'd0);
      check_eq("B_score_cleared",     32'(bus.score),     32'd0);
      for (int r = 0; r < 4; r++) begin
         wait_led(1'b1, "B_on");
         wait_led(1'b0, "B_off");
      end
      wait_over("B");
      check_eq("B_score",     32'(bus.score),     32'd0);
      check_eq("B_best_rt",   32'(bus.best_rt),   32'hFFFF);
      check_eq("B_last_rt",   32'(bus.last_rt),   32'd0);
      check_eq("B_game_over", 32'(bus.game_over), 32'd1);

      // Game C: hits at 4, 2, 7, 1; longer timer so cycle 7 precedes the timeout.
      delay_cycles = 9;
      start_game();
      play_round(4, "C_r0");
      play_round(2, "C_r1");
      play_round(7, "C_r2");
      check_eq("C_r2_last_rt", 32'(bus.last_rt), 32'd7);
      check_eq("C_r2_best_rt", 32'(bus.best_rt), 32'd2);
      play_round(1, "C_r3");
      wait_over("C");
      check_eq("C_score",   32'(bus.score),   32'd4);
      check_eq("C_last_rt", 32'(bus.last_rt), 32'd1);
      check_eq("C_best_rt", 32'(bus.best_rt), 32'd1);
      delay_cycles = 5;

      // Game D: press coincident with timeout, held button, press in DELAY.
      start_game();
      wait_led(1'b1, "D_r0");
      repeat (5) @(negedge clk);
      bus.btn = 1'b1;   // REACT edge with rt_cnt==5 is also the timeout edge
      @(negedge clk);
      check_eq("D_coincident_score",   32'(bus.score),   32'd1);
      check_eq("D_coincident_last_rt", 32'(bus.last_rt), 32'd5);
      wait_led(1'b1, "D_r1_on");      // button still held across REACT entry
      wait_led(1'b0, "D_r1_off");
      check_eq("D_held_score",   32'(bus.score),   32'd1);
      check_eq("D_held_last_rt", 32'(bus.last_rt), 32'd5);
      bus.btn = 1'b0;
      wait_delay("D_r2");
      check_eq("D_r2_round_idx", 32'(bus.round_idx), 32'd2);
      bus.btn = 1'b1;
      @(negedge clk);
      bus.btn = 1'b0;
      check_eq("D_foul_score",     32'(bus.score),       32'(FOUL_SCORE));
      check_eq("D_foul_start",     32'(bus.start_clock), 32'(FOUL_START));
      check_eq("D_foul_round_idx", 32'(bus.round_idx),   32'd2);
      check_eq("D_foul_busy",      32'(bus.busy),        32'd1);
      for (int r = 2; r < 4; r++) begin
         wait_led(1'b1, "D_on");
         wait_led(1'b0, "D_off");
      end
      wait_over("D");
      check_eq("D_score",   32'(bus.score),   32'(FOUL_SCORE));
      check_eq("D_best_rt", 32'(bus.best_rt), 32'd5);

      // Reset mid-REACT after a scored round.
      start_game();
      play_round(2, "R_r0");
      check_eq("R_r0_score", 32'(bus.score), 32'd1);
      wait_led(1'b1, "R_r1");
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midreact_async");
      @(negedge clk);
      check_reset_vals("midreact_next");
      rst_n = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/reaction_round_sequencer.md
# reaction_round_sequencer

Game-round controller that sits directly upstream of the delay timer. It drives the timer's `start_clock` and consumes `clock_done`. It uses one timer expiry as the random-feel "get ready" delay and a second expiry as the reaction timeout. Per round it lights the prompt LED, measures reaction time in clk cycles, scores hits, and reports results to the display logic.

## Interface
- `ROUNDS`, default 4: rounds per game, ≥1.
- `RT_W`, default 16: reaction-time counter width.
- `SCORE_W`, default 8: score width.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `go`  in  1: start a game (level, sampled).
- `btn`  in  1: player button, already synchronized to clk.
- `clock_done`  in  1: timer expiry flag.
- `start_clock`  out  1: timer enable. Registered.
- `led_on`  out  1: prompt LED.
- `busy`  out  1: game in progress.
- `game_over`  out  1: final results valid.
- `round_idx`  out  $clog2(ROUNDS+1): current round, 0-based.
- `score`  out  SCORE_W: hit count.
- `last_rt`  out  RT_W: most recent hit reaction time.
- `best_rt`  out  RT_W: minimum hit reaction time.

## Operation
- **IDLE.** Enter when `go`=1 is sampled. On entry, clear `score`, `round_idx`, `last_rt`; set `best_rt` to all-ones; clear `game_over`. Next state is DELAY.
- **DELAY.** `start_clock`=1, `led_on`=0. Leave when `clock_done`=1 is sampled; next state is GAP1.
- **GAP1.** `start_clock`=0. Stay while `clock_done`=1. Move to REACT on the first sample with `clock_done`=0. The reaction counter `rt_cnt` resets to 0 on this transition.
- **REACT.** `start_clock`=1, `led_on`=1. `rt_cnt` increments every cycle and saturates at 2^RT_W−1.
  - Hit: a `btn` rising edge (`btn`=1 and previous `btn`=0). Actions:
    - `last_rt` ← `rt_cnt`
    - `best_rt` ← min(`best_rt`, `rt_cnt`)
    - `score`+1, saturating
    - next state GAP2
  - Timeout: `clock_done`=1 with no hit. `score` and `rt` registers are unchanged; next state GAP2.
  - A hit and a timeout in the same cycle count as a hit.
- **GAP2.** `start_clock`=0, `led_on`=0. Wait for `clock_done`=0. Then:
  - if `round_idx`==ROUNDS−1, go to OVER;
  - otherwise `round_idx`+1 and go to DELAY.
- **OVER.** `game_over`=1, `busy`=0. All results hold. `go`=1 starts a new game with the same clearing as IDLE.
- `busy`=1 in DELAY, GAP1, REACT and GAP2. `go` is ignored in those states.
- A `btn` held high when entering REACT is not a hit; a fresh rising edge is required.
- `rst_n` low at any time, including mid-round, forces IDLE immediately. Outputs: `start_clock`, `led_on`, `busy`, `game_over`, `round_idx`, `score`, `last_rt` = 0; `best_rt` = all-ones; previous-`btn` register = 0.

## Timing
- All outputs are registered and change only on the clk edge (except asynchronous reset).
- `go` sampled at edge k → `start_clock`=1 and `busy`=1 after edge k.
- `clock_done` sampled at edge k in DELAY or REACT → `start_clock`=0 after edge k.
- GAP states last ≥1 cycle and end only when `clock_done` is observed low. This guarantees the timer counter is cleared before re-arming.
- Hit at edge k → `score`, `last_rt`, `best_rt` and `led_on`=0 are visible after edge k.
- `rt_cnt` is 0 in the first REACT cycle, so a press detected at the first REACT edge yields `last_rt`=0.

## Configuration
- `REACT_SEQ_EARLY_PENALTY_EN`
  - Defined: a `btn` rising edge during DELAY is a foul. `score` decrements (saturating at 0) and the state goes to GAP1′. GAP1′ behaves like GAP1 but returns to DELAY, which restarts the delay in the same round.
  - Undefined: `btn` is ignored outside REACT.

## Structure
- Shared package `sequencer_pkg` holds:
  - state enum: IDLE, DELAY, GAP1, REACT, GAP2, OVER, plus GAP1′ when the macro is enabled;
  - saturating increment/decrement helper functions;
  - default-parameter constants.
- One sub-module, `rise_detect`: registered previous-`btn` plus combinational rising-edge pulse, with `rst_n` clearing the register.
- The timer is not instantiated here; connection happens at top level.

## Test plan
The bench uses a timer model that asserts `clock_done` D=5 cycles after `start_clock` rises and clears it one cycle after `start_clock` falls.
- Reset mid-REACT → all outputs at reset values next cycle; `best_rt`=0xFFFF.
- `go` pulse, `btn` edge on REACT cycle 3 in every round, ROUNDS=4 → `score`=4, `last_rt`=`best_rt`=3, `game_over`=1, `round_idx`=3.
- No presses → 4 timeouts: `score`=0, `best_rt`=0xFFFF, `game_over`=1.
- `btn` edges on REACT cycles 4, 2, 7, 1 → `best_rt`=1, `last_rt`=1, `score`=4.
- `btn` edge coincident with `clock_done` in REACT → counted as hit; `btn` held high across REACT entry → no hit.
- Macro defined: press in DELAY with `score`=1 → `score`=0, delay restarts, `round_idx` unchanged. Macro undefined: same stimulus → no effect.
